// File: rtl/adder_16bit_pipe_if.sv
// Operand/result handshake bundle for adder_16bit_pipe.
// The ovf signal exists only when ADDER_16BIT_PIPE_OVF_EN is defined.
interface adder_16bit_pipe_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
`ifdef ADDER_16BIT_PIPE_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, c_in, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf
   );
   modport slave (
      input  in_valid, a, b, c_in, out_ready,
      output in_ready, out_valid, sum, c_out, ovf
   );
`else
   modport master (
      output in_valid, a, b, c_in, out_ready,
      input  in_ready, out_valid, sum, c_out
   );
   modport slave (
      input  in_valid, a, b, c_in, out_ready,
      output in_ready, out_valid, sum, c_out
   );
`endif
endinterface

// File: rtl/adder_16bit_pipe.sv
// Pipelined ripple-carry adder: one SLICE_W-bit slice per stage, valid/ready on both sides.
// Define ADDER_16BIT_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module adder_16bit_pipe #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned SLICE_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   adder_16bit_pipe_if.slave bus
);
   localparam int unsigned STAGES = WIDTH / SLICE_W;
   localparam int unsigned LAST   = STAGES - 1;
   localparam int unsigned OPW    = WIDTH - SLICE_W;

   logic [STAGES-1:0]             valid_r;
   logic [STAGES-1:0]             carry_r;
   logic [STAGES-1:0][WIDTH-1:0]  sum_r;
   // Operands are shifted right one slice per stage so the next slice is always at bit 0.
   logic [STAGES-2:0][OPW-1:0]    a_r;
   logic [STAGES-2:0][OPW-1:0]    b_r;

   logic [STAGES-1:0]             ready;
   logic [STAGES-1:0]             v_src;
   logic [STAGES-1:0]             c_src;
   logic [STAGES-1:0]             c_nxt;
   logic [STAGES-1:0][WIDTH-1:0]  a_src;
   logic [STAGES-1:0][WIDTH-1:0]  b_src;
   logic [STAGES-1:0][WIDTH-1:0]  s_src;
   logic [STAGES-1:0][WIDTH-1:0]  s_nxt;
   logic [STAGES-1:0][SLICE_W:0]  slice_res;
   logic                          full;

   function automatic logic [SLICE_W:0] slice_add(
      input logic [SLICE_W-1:0] x,
      input logic [SLICE_W-1:0] y,
      input logic               ci
   );
      logic               c;
      logic [SLICE_W-1:0] s;
      c = ci;
      s = '0;
      for (int unsigned i = 0; i < SLICE_W; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c, s};
   endfunction

   always_comb begin
      ready     = '0;
      v_src     = '0;
      c_src     = '0;
      c_nxt     = '0;
      a_src     = '0;
      b_src     = '0;
      s_src     = '0;
      s_nxt     = '0;
      slice_res = '0;

      // ready_k = !valid_k || ready_(k+1), unrolled as "not every stage from k to the end is full".
      full = 1'b1;
      for (int unsigned i = 0; i < STAGES; i++) begin
         full             = full & valid_r[LAST - i];
         ready[LAST - i]  = !full || bus.out_ready;
      end

      v_src[0] = bus.in_valid;
      a_src[0] = bus.a;
      b_src[0] = bus.b;
      c_src[0] = bus.c_in;
      for (int unsigned k = 1; k < STAGES; k++) begin
         v_src[k] = valid_r[k-1];
         a_src[k] = {{SLICE_W{1'b0}}, a_r[k-1]};
         b_src[k] = {{SLICE_W{1'b0}}, b_r[k-1]};
         s_src[k] = sum_r[k-1];
         c_src[k] = carry_r[k-1];
      end

      for (int unsigned k = 0; k < STAGES; k++) begin
         slice_res[k]                       = slice_add(a_src[k][SLICE_W-1:0],
                                                        b_src[k][SLICE_W-1:0], c_src[k]);
         s_nxt[k]                           = s_src[k];
         s_nxt[k][k*SLICE_W +: SLICE_W]     = slice_res[k][SLICE_W-1:0];
         c_nxt[k]                           = slice_res[k][SLICE_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= '0;
         carry_r <= '0;
         sum_r   <= '0;
         a_r     <= '0;
         b_r     <= '0;
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (ready[k]) begin
               valid_r[k] <= v_src[k];
               if (v_src[k]) begin
                  sum_r[k]   <= s_nxt[k];
                  carry_r[k] <= c_nxt[k];
               end
            end
         end
         for (int unsigned k = 0; k < STAGES - 1; k++) begin
            if (ready[k] && v_src[k]) begin
               a_r[k] <= a_src[k][WIDTH-1:SLICE_W];
               b_r[k] <= b_src[k][WIDTH-1:SLICE_W];
            end
         end
      end
   end

   assign bus.in_ready  = ready[0];
   assign bus.out_valid = valid_r[LAST];
   assign bus.sum       = sum_r[LAST];
   assign bus.c_out     = carry_r[LAST];

`ifdef ADDER_16BIT_PIPE_OVF_EN
   logic ovf_r;
   logic ovf_nxt;

   // Carry into the MSB equals a_msb ^ b_msb ^ sum_msb.
   assign ovf_nxt = a_src[LAST][SLICE_W-1] ^ b_src[LAST][SLICE_W-1]
                  ^ s_nxt[LAST][WIDTH-1] ^ c_nxt[LAST];

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (ready[LAST] && v_src[LAST]) begin
         ovf_r <= ovf_nxt;
      end
   end

   assign bus.ovf = ovf_r;
`endif
endmodule
